// File: rtl/mmio_io_ctrl_if.sv
// Core data bus view of the I/O region: region decode, strobes, byte offset, data.
interface mmio_io_ctrl_if;
  logic        SEL;
  logic        WE;
  logic        RE;
  logic [3:0]  ADDR;
  logic [31:0] WD;
  logic [31:0] RD;

  modport master (output SEL, WE, RE, ADDR, WD, input RD);
  modport slave  (input SEL, WE, RE, ADDR, WD, output RD);
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: DIP switches, LEDs, hex register, display
// control, and a multiplexed 7-segment scanner.
// Optional macro DIP_DEBOUNCE_EN adds a per-bit debouncer after the DIP synchroniser.
module mmio_io_ctrl #(
  parameter int DIP_W      = 7,
  parameter int LED_W      = 16,
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 16,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  mmio_io_ctrl_if.slave           bus,
  input  logic [DIP_W-1:0]        DIP,
  output logic [LED_W-1:0]        LED,
  output logic [4*NUM_DIGITS-1:0] SEVENSEGHEX,
  output logic [NUM_DIGITS-1:0]   SEG_AN,
  output logic [7:0]              SEG_CAT
);
  localparam int HEX_W  = 4*NUM_DIGITS;
  localparam int CTRL_W = NUM_DIGITS + 1;
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CTRL_W-1:0]     ctrl;
  logic [DIP_W-1:0]      dip_s1, dip_reg;
  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           rd_val;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [3:0]            nib;
  logic [7:0]            cat_nxt;

  // Byte-lane bits of the offset carry no meaning; WD is consumed per register.
  logic unused;
  assign unused = ^{bus.ADDR[1:0], bus.WD};

  // Register read mux, zero-extended to the bus width.
  always_comb begin
    rd_val = '0;
    case (bus.ADDR[3:2])
      2'd0:    rd_val = 32'(dip_reg);
      2'd1:    rd_val = 32'(LED);
      2'd2:    rd_val = 32'(SEVENSEGHEX);
      default: rd_val = 32'(ctrl);
    endcase
  end

  // Bus registers; RD captures the pre-write value so read+write returns old data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LED         <= '0;
      SEVENSEGHEX <= '0;
      ctrl        <= CTRL_W'(1);
      bus.RD      <= '0;
    end else begin
      bus.RD <= (bus.SEL && bus.RE) ? rd_val : '0;
      if (bus.SEL && bus.WE) begin
        case (bus.ADDR[3:2])
          2'd1:    LED         <= bus.WD[LED_W-1:0];
          2'd2:    SEVENSEGHEX <= bus.WD[HEX_W-1:0];
          2'd3:    ctrl        <= bus.WD[CTRL_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef DIP_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  logic [DIP_W-1:0]            dip_s2;
  logic [DIP_W-1:0][CNT_W-1:0] deb_cnt;

  // Two-flop synchroniser, then a run-length filter per bit: the register bit
  // flips only after DEB_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dip_s1  <= '0;
      dip_s2  <= '0;
      dip_reg <= '0;
      deb_cnt <= '0;
    end else begin
      dip_s1 <= DIP;
      dip_s2 <= dip_s1;
      for (int i = 0; i < DIP_W; i++) begin
        if (dip_s2[i] == dip_reg[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          dip_reg[i] <= dip_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Two-flop synchroniser; the second flop is the DIP register itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dip_s1  <= '0;
      dip_reg <= '0;
    end else begin
      dip_s1  <= DIP;
      dip_reg <= dip_s1;
    end
  end
`endif

  // Anode pattern for the current digit, gated by enable and blank mask.
  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IDX_W'(i) == idx && ctrl[0] && !ctrl[i+1]) an_nxt[i] = 1'b0;
  end

  // Active-low glyph decode of the current digit's nibble; dp stays off.
  always_comb begin
    nib = SEVENSEGHEX[4*idx +: 4];
    case (nib)
      4'h0: cat_nxt = 8'hC0;  4'h1: cat_nxt = 8'hF9;
      4'h2: cat_nxt = 8'hA4;  4'h3: cat_nxt = 8'hB0;
      4'h4: cat_nxt = 8'h99;  4'h5: cat_nxt = 8'h92;
      4'h6: cat_nxt = 8'h82;  4'h7: cat_nxt = 8'hF8;
      4'h8: cat_nxt = 8'h80;  4'h9: cat_nxt = 8'h90;
      4'hA: cat_nxt = 8'h88;  4'hB: cat_nxt = 8'h83;
      4'hC: cat_nxt = 8'hC6;  4'hD: cat_nxt = 8'hA1;
      4'hE: cat_nxt = 8'h86;  default: cat_nxt = 8'h8E;
    endcase
  end

  // Scan prescaler and digit index; anodes and cathodes register together so
  // they never skew, and digit 0 shows on the first edge out of reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre     <= '0;
      idx     <= '0;
      SEG_AN  <= '1;
      SEG_CAT <= 8'hFF;
    end else begin
      SEG_AN  <= an_nxt;
      SEG_CAT <= cat_nxt;
      if (pre == PRE_W'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboard bench for mmio_io_ctrl: the stimulus process predicts every
// cycle's outputs from a register-level model and queues them; a monitor
// compares after each rising edge.
module tb_mmio_io_ctrl;
  localparam int DIP_W = 7, LED_W = 16, ND = 8, SD = 4, DEB = 4;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [DIP_W-1:0]  DIP;
  logic [LED_W-1:0]  LED;
  logic [4*ND-1:0]   SEVENSEGHEX;
  logic [ND-1:0]     SEG_AN;
  logic [7:0]        SEG_CAT;

  mmio_io_ctrl_if bus();

  mmio_io_ctrl #(.DIP_W(DIP_W), .LED_W(LED_W), .NUM_DIGITS(ND),
                 .SCAN_DIV(SD), .DEB_CYCLES(DEB)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .DIP(DIP), .LED(LED),
    .SEVENSEGHEX(SEVENSEGHEX), .SEG_AN(SEG_AN), .SEG_CAT(SEG_CAT));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] rd;
    logic [15:0] led;
    logic [31:0] hex;
    logic [7:0]  an;
    logic [7:0]  cat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0]      m_led;
  logic [31:0]      m_hex;
  logic [8:0]       m_ctrl;
  int               m_t;          // non-reset edges since the last reset
  logic [DIP_W-1:0] m_hist[$];    // switch samples, oldest first
  logic [DIP_W-1:0] m_dip;
`ifdef DIP_DEBOUNCE_EN
  int               m_run[DIP_W];
`endif
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [DIP_W-1:0] dip_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One bus cycle: drive inputs, predict the outputs after the coming edge.
  task automatic step(input logic rst, input logic sel, input logic we, input logic re,
                      input logic [3:0] addr, input logic [31:0] wd);
    exp_t e;
    int d;
    logic [DIP_W-1:0] syn, pre_dip;
    @(negedge CLK);
    RESET = rst; bus.SEL = sel; bus.WE = we; bus.RE = re; bus.ADDR = addr; bus.WD = wd;
    DIP = dip_v;
    if (rst) begin
      m_led = '0; m_hex = '0; m_ctrl = 9'd1; m_t = 0; m_dip = '0;
      m_hist = '{};
      m_hist.push_back('0); m_hist.push_back('0);
`ifdef DIP_DEBOUNCE_EN
      foreach (m_run[b]) m_run[b] = 0;
`endif
      e.rd = '0; e.an = 8'hFF; e.cat = 8'hFF;
    end else begin
      // Value the synchronised switch path presents at this edge.
      syn = m_hist[0];
`ifdef DIP_DEBOUNCE_EN
      pre_dip = m_dip;
`else
      pre_dip = syn;
`endif
      e.rd = '0;
      if (sel && re) begin
        case (addr[3:2])
          2'd0: e.rd = 32'(pre_dip);
          2'd1: e.rd = 32'(m_led);
          2'd2: e.rd = m_hex;
          default: e.rd = 32'(m_ctrl);
        endcase
      end
      d = (m_t / SD) % ND;
      e.an = 8'hFF;
      if (m_ctrl[0] && !m_ctrl[d+1]) e.an[d] = 1'b0;
      e.cat = glyph[m_hex[4*d +: 4]];
      if (sel && we) begin
        case (addr[3:2])
          2'd1: m_led = wd[15:0];
          2'd2: m_hex = wd;
          2'd3: m_ctrl = wd[8:0];
          default: ;
        endcase
      end
`ifdef DIP_DEBOUNCE_EN
      for (int b = 0; b < DIP_W; b++) begin
        if (syn[b] == m_dip[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DEB) begin m_dip[b] = syn[b]; m_run[b] = 0; end
        end
      end
`endif
      m_hist.push_back(dip_v);
      void'(m_hist.pop_front());
      m_t++;
    end
    e.led = m_led;
    e.hex = m_hex;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic rd_loop(input logic [3:0] addr, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1, addr, 32'h0);
  endtask

  // Monitor: compare every presented output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("RD", bus.RD, e.rd);
        chk("LED", 32'(LED), 32'(e.led));
        chk("SEVENSEGHEX", SEVENSEGHEX, e.hex);
        chk("SEG_AN", 32'(SEG_AN), 32'(e.an));
        chk("SEG_CAT", 32'(SEG_CAT), 32'(e.cat));
      end
    end
  end

  initial begin
    RESET = 1'b1; bus.SEL = 1'b0; bus.WE = 1'b0; bus.RE = 1'b0;
    bus.ADDR = '0; bus.WD = '0; dip_v = '0; DIP = '0;

    // Reset held two cycles with a write strobe active
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h4, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h8, 32'hFFFF_FFFF);

    // LED write/read, write to read-only DIP, read+write same address
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 32'hDEAD_ABCD);
    rd_loop(4'h4, 2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h5);
    rd_loop(4'h0, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'h4, 32'h0000_1234);
    rd_loop(4'h4, 1);

    // Hex scan over more than one full wrap, plus a mid-scan rewrite
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 32'h1234_5678);
    idle(40);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h8, 32'h9ABC_DEF0);
    rd_loop(4'h8, 20);

    // DIP level change, then a 2-cycle pulse, then a held level
    dip_v = 7'b0001100;
    rd_loop(4'h0, 8);
    dip_v = 7'b0001101;
    rd_loop(4'h0, 2);
    dip_v = 7'b0001100;
    rd_loop(4'h0, 10);
    dip_v = 7'b0001101;
    rd_loop(4'h0, 12);

    // Blank digit 0, disable display, re-enable
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 32'h3);
    rd_loop(4'hC, 36);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 32'h0);
    idle(12);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 32'h1);
    idle(4);

    // Reset while digit 3 is being scanned
    while ((m_t / SD) % ND != 3) idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    idle(10);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) dip_v = dip_v ^ DIP_W'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom), 1'($urandom), 4'($urandom), $urandom);
    end
    idle(2);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d expected 0 pending", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
